// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter and other round-robin
// shared-resource blocks.
package mem_arb_pkg;

  localparam int MEM_ADDR_BITS   = 10;
  localparam int DEFAULT_NUM_REQ = 2;
  localparam int MAX_NUM_REQ     = 4;

  // Index width is clog2 of the requester count, never below 1 bit; sized for
  // the largest supported requester count so one type serves every instance.
  localparam int REQ_IDX_W = ($clog2(MAX_NUM_REQ) < 1) ? 1 : $clog2(MAX_NUM_REQ);

  typedef logic [REQ_IDX_W-1:0]   req_idx_t;
  typedef logic [MAX_NUM_REQ-1:0] req_vec_t;

  // One-hot round-robin pick: scan from ptr upward, wrapping at n, first set
  // valid bit wins. Bits at or above n are never granted.
  function automatic req_vec_t rr_pick(input req_vec_t valid, input req_idx_t ptr,
                                       input int n);
    req_vec_t gnt;
    req_idx_t idx;
    logic     found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NUM_REQ; k++) begin
      idx = req_idx_t'((int'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant plus the registered
// rotating priority pointer. No grant is issued while reset is asserted.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_any_o
);

  req_idx_t rr_ptr;
  req_idx_t rr_ptr_nxt;
  req_vec_t pick;

  // Grant selection, gated off during reset.
  always_comb begin
    pick      = rr_pick(req_vec_t'(req_i), rr_ptr, NUM_REQ);
    gnt_any_o = reset_n_i & (|pick);
    gnt_o     = reset_n_i ? pick[NUM_REQ-1:0] : '0;
  end

  // Pointer moves to the requester just after the winner; holds when idle.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_o[i]) rr_ptr_nxt = (i == NUM_REQ - 1) ? '0 : req_idx_t'(i + 1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!reset_n_i) rr_ptr <= '0;
    else            rr_ptr <= rr_ptr_nxt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency memory between NUM_REQ requesters.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic                      perf_clr_i,
  output logic [NUM_REQ*32-1:0]     wait_cnt_o
`endif
);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_v;
  logic [NUM_REQ-1:0]             gnt;
  logic                           gnt_any;
  logic [NUM_REQ-1:0]             rsp_tag;
  logic [ADDR_W-1:0]              addr_sel;
  logic [DATA_W-1:0]              wdata_sel;
  logic                           we_sel;

  assign addr_v  = req_addr_i;
  assign wdata_v = req_wdata_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .req_i     (req_valid_i),
    .gnt_o     (gnt),
    .gnt_any_o (gnt_any)
  );

  assign req_ready_o = gnt;

  // One-hot AND-OR mux of the winner onto the memory port; all zero when idle.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        addr_sel  = addr_sel  | addr_v[i];
        wdata_sel = wdata_sel | wdata_v[i];
        we_sel    = we_sel    | req_we_i[i];
      end
    end
    mem_addr_o  = gnt_any ? addr_sel  : '0;
    mem_wdata_o = gnt_any ? wdata_sel : '0;
    mem_we_o    = gnt_any & we_sel;
  end

  // Response tag: the grant delayed by the memory's read latency. Reset drops
  // any in-flight response.
  always_ff @(posedge clk) begin
    if (!reset_n_i) rsp_tag <= '0;
    else            rsp_tag <= gnt;
  end

  assign rsp_valid_o = rsp_tag;
  assign rsp_rdata_o = mem_rdata_i;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] wait_cnt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    // Saturating count of stalled cycles; clear beats increment.
    always_ff @(posedge clk) begin
      if (!reset_n_i || perf_clr_i)
        wait_cnt[i] <= '0;
      else if (req_valid_i[i] && !gnt[i] && wait_cnt[i] != 32'hFFFF_FFFF)
        wait_cnt[i] <= wait_cnt[i] + 32'd1;
    end
    assign wait_cnt_o[i*32 +: 32] = wait_cnt[i];
  end
`endif

endmodule
